// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
// Round-robin or fixed-priority (with B anti-starvation) arbitration; read data is routed back to the issuer.
`default_nettype none

module ram_arbiter #(
  parameter int DEPTH          = 2**14,
  parameter int WIDTH          = 16,
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_B_WAIT     = 8,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_A_Req,
  input  logic             i_A_Write_EN,
  input  logic [AW-1:0]    i_A_Address,
  input  logic [WIDTH-1:0] i_A_Data,
  output logic             o_A_Grant,
  output logic             o_A_Rd_Valid,
  output logic [WIDTH-1:0] o_A_Data,
  input  logic             i_B_Req,
  input  logic             i_B_Write_EN,
  input  logic [AW-1:0]    i_B_Address,
  input  logic [WIDTH-1:0] i_B_Data,
  output logic             o_B_Grant,
  output logic             o_B_Rd_Valid,
  output logic [WIDTH-1:0] o_B_Data,
  output logic [AW-1:0]    o_Ram_Address,
  output logic [WIDTH-1:0] o_Ram_Data,
  output logic             o_Ram_Write_EN,
  input  logic [WIDTH-1:0] i_Ram_Data
);

  localparam logic [7:0] MAX_WAIT = 8'(MAX_B_WAIT);

  logic       rr_ptr_q, rr_ptr_d;        // 0 = A preferred, 1 = B preferred
  logic [7:0] b_wait_q, b_wait_d;
  logic       a_rd_valid_q, a_rd_valid_d;
  logic       b_rd_valid_q, b_rd_valid_d;
  logic       a_grant, b_grant;
  logic       both_req;

  assign both_req = i_A_Req && i_B_Req;

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (i_RST_N) begin
      if (both_req) begin
        if (FIXED_PRIORITY != 0) begin
          if (b_wait_q == MAX_WAIT) b_grant = 1'b1;
          else                      a_grant = 1'b1;
        end else begin
          if (rr_ptr_q) b_grant = 1'b1;
          else          a_grant = 1'b1;
        end
      end else begin
        a_grant = i_A_Req;
        b_grant = i_B_Req;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (both_req && (a_grant || b_grant)) rr_ptr_d = ~rr_ptr_q;

    b_wait_d = 8'd0;
    if (i_B_Req && !b_grant) begin
      b_wait_d = (b_wait_q == MAX_WAIT) ? b_wait_q : b_wait_q + 8'd1;
    end

    a_rd_valid_d = a_grant && !i_A_Write_EN;
    b_rd_valid_d = b_grant && !i_B_Write_EN;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      rr_ptr_q     <= 1'b0;
      b_wait_q     <= 8'd0;
      a_rd_valid_q <= 1'b0;
      b_rd_valid_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      b_wait_q     <= b_wait_d;
      a_rd_valid_q <= a_rd_valid_d;
      b_rd_valid_q <= b_rd_valid_d;
    end
  end

  assign o_A_Grant      = a_grant;
  assign o_B_Grant      = b_grant;
  assign o_Ram_Address  = b_grant ? i_B_Address : i_A_Address;
  assign o_Ram_Data     = b_grant ? i_B_Data    : i_A_Data;
  assign o_Ram_Write_EN = (a_grant && i_A_Write_EN) || (b_grant && i_B_Write_EN);

  // Gating with reset suppresses a return that coincides with reset being asserted.
  assign o_A_Rd_Valid = a_rd_valid_q && i_RST_N;
  assign o_B_Rd_Valid = b_rd_valid_q && i_RST_N;
  assign o_A_Data     = o_A_Rd_Valid ? i_Ram_Data : '0;
  assign o_B_Data     = o_B_Rd_Valid ? i_Ram_Data : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter: round-robin (dut0) and fixed-priority (dut1) instances share stimulus.
`default_nettype none

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [13:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic        a_grant0, a_rv0, b_grant0, b_rv0, ram_we0;
  logic [15:0] a_rd0, b_rd0, ram_wd0, ram_rd0;
  logic [13:0] ram_addr0;
  logic        a_grant1, a_rv1, b_grant1, b_rv1, ram_we1;
  logic [15:0] a_rd1, b_rd1, ram_wd1, ram_rd1;
  logic [13:0] ram_addr1;

  logic [15:0] mem0 [0:16383];
  logic [15:0] mem1 [0:16383];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.FIXED_PRIORITY(0), .MAX_B_WAIT(8)) dut0 (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_A_Req(a_req), .i_A_Write_EN(a_we), .i_A_Address(a_addr), .i_A_Data(a_wdata),
    .o_A_Grant(a_grant0), .o_A_Rd_Valid(a_rv0), .o_A_Data(a_rd0),
    .i_B_Req(b_req), .i_B_Write_EN(b_we), .i_B_Address(b_addr), .i_B_Data(b_wdata),
    .o_B_Grant(b_grant0), .o_B_Rd_Valid(b_rv0), .o_B_Data(b_rd0),
    .o_Ram_Address(ram_addr0), .o_Ram_Data(ram_wd0), .o_Ram_Write_EN(ram_we0),
    .i_Ram_Data(ram_rd0)
  );

  ram_arbiter #(.FIXED_PRIORITY(1), .MAX_B_WAIT(3)) dut1 (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_A_Req(a_req), .i_A_Write_EN(a_we), .i_A_Address(a_addr), .i_A_Data(a_wdata),
    .o_A_Grant(a_grant1), .o_A_Rd_Valid(a_rv1), .o_A_Data(a_rd1),
    .i_B_Req(b_req), .i_B_Write_EN(b_we), .i_B_Address(b_addr), .i_B_Data(b_wdata),
    .o_B_Grant(b_grant1), .o_B_Rd_Valid(b_rv1), .o_B_Data(b_rd1),
    .o_Ram_Address(ram_addr1), .o_Ram_Data(ram_wd1), .o_Ram_Write_EN(ram_we1),
    .i_Ram_Data(ram_rd1)
  );

  // Behavioural single-port RAMs: registered read, read returns old data on a write.
  always @(posedge clk) begin
    if (ram_we0) mem0[ram_addr0] <= ram_wd0;
    ram_rd0 <= mem0[ram_addr0];
    if (ram_we1) mem1[ram_addr1] <= ram_wd1;
    ram_rd1 <= mem1[ram_addr1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
  endtask

  task automatic preload();
    for (int k = 0; k < 6; k++) begin
      tick(); a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0010 + 14'(k); a_wdata = 16'hA000 + 16'(k);
      tick(); a_addr = 14'h0020 + 14'(k); a_wdata = 16'hB000 + 16'(k);
    end
    tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (a_grant0 !== 1'b0) begin errors++; $display("FAIL rst_a_grant cyc%0d: got %b expected 0", i, a_grant0); end
      checks++; if (b_grant0 !== 1'b0) begin errors++; $display("FAIL rst_b_grant cyc%0d: got %b expected 0", i, b_grant0); end
      checks++; if (ram_we0 !== 1'b0) begin errors++; $display("FAIL rst_ram_we cyc%0d: got %b expected 0", i, ram_we0); end
      checks++; if ({a_rv0, b_rv0} !== 2'b00) begin errors++; $display("FAIL rst_rd_valid cyc%0d: got %b expected 00", i, {a_rv0, b_rv0}); end
      checks++; if ({a_grant1, b_grant1} !== 2'b00) begin errors++; $display("FAIL rst_grants_fp cyc%0d: got %b expected 00", i, {a_grant1, b_grant1}); end
    end
    rst_n = 1'b1; #1;
    checks++; if ({a_grant0, b_grant0} !== 2'b10) begin errors++; $display("FAIL rst_release_rr: got %b expected 10", {a_grant0, b_grant0}); end
    checks++; if ({a_grant1, b_grant1} !== 2'b10) begin errors++; $display("FAIL rst_release_fp: got %b expected 10", {a_grant1, b_grant1}); end
    tick(); idle();
  endtask

  task automatic test_single();
    tick(); a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0005; a_wdata = 16'h1234; #1;
    checks++; if ({a_grant0, ram_we0} !== 2'b11) begin errors++; $display("FAIL single_wr_grant: got %b expected 11", {a_grant0, ram_we0}); end
    tick(); a_we = 1'b0; #1;
    checks++; if ({a_grant0, ram_we0, a_rv0} !== 3'b100) begin errors++; $display("FAIL single_rd_grant: got %b expected 100", {a_grant0, ram_we0, a_rv0}); end
    tick(); idle(); #1;
    checks++; if (a_rv0 !== 1'b1 || a_rd0 !== 16'h1234) begin errors++; $display("FAIL single_rd_data: got v=%b d=%h expected v=1 d=1234", a_rv0, a_rd0); end
    checks++; if (b_rv0 !== 1'b0 || b_rd0 !== 16'h0000) begin errors++; $display("FAIL single_b_quiet: got v=%b d=%h expected v=0 d=0000", b_rv0, b_rd0); end
    tick(); #1;
    checks++; if (a_rv0 !== 1'b0 || a_rd0 !== 16'h0000) begin errors++; $display("FAIL single_rd_once: got v=%b d=%h expected v=0 d=0000", a_rv0, a_rd0); end
  endtask

  task automatic test_round_robin();
    int ka = 0, kb = 0;
    int prev_a = -1, prev_b = -1;
    logic exp_a;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 6) begin
        a_req = 1'b1; b_req = 1'b1;
        a_addr = 14'h0010 + 14'(ka); b_addr = 14'h0020 + 14'(kb);
      end else idle();
      #1;
      checks++; if (a_rv0 !== (prev_a >= 0) || a_rd0 !== ((prev_a >= 0) ? 16'(prev_a) : 16'h0000))
        begin errors++; $display("FAIL rr_a_data cyc%0d: got v=%b d=%h expected v=%0d d=%h", i, a_rv0, a_rd0, prev_a >= 0, (prev_a >= 0) ? 16'(prev_a) : 16'h0); end
      checks++; if (b_rv0 !== (prev_b >= 0) || b_rd0 !== ((prev_b >= 0) ? 16'(prev_b) : 16'h0000))
        begin errors++; $display("FAIL rr_b_data cyc%0d: got v=%b d=%h expected v=%0d d=%h", i, b_rv0, b_rd0, prev_b >= 0, (prev_b >= 0) ? 16'(prev_b) : 16'h0); end
      prev_a = -1; prev_b = -1;
      if (i < 6) begin
        exp_a = (i % 2 == 0);
        checks++; if ({a_grant0, b_grant0} !== {exp_a, ~exp_a}) begin errors++; $display("FAIL rr_grant cyc%0d: got %b expected %b", i, {a_grant0, b_grant0}, {exp_a, ~exp_a}); end
        if (exp_a) begin prev_a = 'hA000 + ka; ka++; end
        else       begin prev_b = 'hB000 + kb; kb++; end
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic exp_b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(); a_req = 1'b1; b_req = 1'b1; a_addr = 14'h0010; b_addr = 14'h0020; #1;
      exp_b = (i % 4 == 3);
      checks++; if ({a_grant1, b_grant1} !== {~exp_b, exp_b}) begin errors++; $display("FAIL fp_grant cyc%0d: got %b expected %b", i, {a_grant1, b_grant1}, {~exp_b, exp_b}); end
    end
    tick(); idle();
  endtask

  task automatic test_hazard();
    tick(); b_req = 1'b1; b_we = 1'b1; b_addr = 14'h3FFF; b_wdata = 16'hBEEF; #1;
    checks++; if ({b_grant0, ram_we0, ram_addr0} !== {2'b11, 14'h3FFF}) begin errors++; $display("FAIL hz_write: got g=%b we=%b a=%h expected g=1 we=1 a=3fff", b_grant0, ram_we0, ram_addr0); end
    tick(); idle(); a_req = 1'b1; a_addr = 14'h3FFF; #1;
    checks++; if (a_grant0 !== 1'b1) begin errors++; $display("FAIL hz_read_grant: got %b expected 1", a_grant0); end
    tick(); idle(); #1;
    checks++; if (a_rv0 !== 1'b1 || a_rd0 !== 16'hBEEF) begin errors++; $display("FAIL hz_read_data: got v=%b d=%h expected v=1 d=beef", a_rv0, a_rd0); end
  endtask

  task automatic test_back_to_back();
    tick(); a_req = 1'b1; a_addr = 14'h0012; #1;
    checks++; if (a_grant0 !== 1'b1) begin errors++; $display("FAIL b2b_a_grant: got %b expected 1", a_grant0); end
    tick(); idle(); b_req = 1'b1; b_addr = 14'h0023; #1;
    checks++; if (b_grant0 !== 1'b1 || a_rv0 !== 1'b1 || a_rd0 !== 16'hA002) begin errors++; $display("FAIL b2b_n1: got bg=%b av=%b ad=%h expected bg=1 av=1 ad=a002", b_grant0, a_rv0, a_rd0); end
    tick(); idle(); #1;
    checks++; if (b_rv0 !== 1'b1 || b_rd0 !== 16'hB003 || a_rv0 !== 1'b0) begin errors++; $display("FAIL b2b_n2: got bv=%b bd=%h av=%b expected bv=1 bd=b003 av=0", b_rv0, b_rd0, a_rv0); end
  endtask

  task automatic test_reset_mid_read();
    tick(); a_req = 1'b1; a_addr = 14'h0005; #1;
    checks++; if (a_grant0 !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b expected 1", a_grant0); end
    tick(); rst_n = 1'b0; #1;
    checks++; if ({a_rv0, b_rv0, a_rv1, b_rv1} !== 4'b0000) begin errors++; $display("FAIL rmid_n1_valid: got %b expected 0000", {a_rv0, b_rv0, a_rv1, b_rv1}); end
    checks++; if (a_grant0 !== 1'b0) begin errors++; $display("FAIL rmid_rst_grant: got %b expected 0", a_grant0); end
    tick(); idle(); rst_n = 1'b1; #1;
    checks++; if ({a_rv0, b_rv0, a_rv1, b_rv1} !== 4'b0000) begin errors++; $display("FAIL rmid_n2_valid: got %b expected 0000", {a_rv0, b_rv0, a_rv1, b_rv1}); end
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_single();
    preload();
    test_round_robin();
    test_fixed_priority();
    test_hazard();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
